// File: rtl/score_accumulator.sv
// Rhythm-game score keeper: turns per-hit judgements into a saturating score,
// a combo count and a max-combo count, gated by an IDLE/PLAY/DONE phase FSM.
module score_accumulator #(
    parameter int unsigned PTS_OK      = 1,
    parameter int unsigned PTS_GOOD    = 2,
    parameter int unsigned PTS_PERFECT = 5,
    parameter int unsigned COMBO_X2    = 10,
    parameter int unsigned COMBO_X3    = 30,
    parameter int unsigned COMBO_X4    = 50,
    parameter int unsigned SCORE_MAX   = 9999
) (
    input  logic        segclk,
    input  logic        clr,
    input  logic        game_start,
    input  logic        game_end,
    input  logic        hit_valid,
    input  logic [1:0]  hit_grade,
    output logic [14:0] score,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo,
    output logic        playing,
    output logic        game_over
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0]  GRADE_MISS    = 2'd0;
    localparam logic [1:0]  GRADE_OK      = 2'd1;
    localparam logic [1:0]  GRADE_GOOD    = 2'd2;
    localparam logic [1:0]  GRADE_PERFECT = 2'd3;
    localparam logic [7:0]  COMBO_SAT     = 8'hFF;
    localparam logic [15:0] SCORE_MAX_W   = 16'(SCORE_MAX);

    state_t      state_q, state_d;
    logic [14:0] score_q, score_d;
    logic [7:0]  combo_q, combo_d;
    logic [7:0]  max_combo_q, max_combo_d;
    logic        playing_q, playing_d;
    logic        game_over_q, game_over_d;

    // Datapath for a single judgement, evaluated every cycle and used only in PLAY.
    logic [2:0]  base_pts;
    logic [2:0]  mult;
    logic [5:0]  add_full;
    logic [4:0]  add_pts;
    logic [7:0]  new_combo;
    logic [15:0] score_sum;
    logic [14:0] score_sat;

    always_comb begin
        base_pts = 3'd0;
        case (hit_grade)
            GRADE_OK:      base_pts = 3'(PTS_OK);
            GRADE_GOOD:    base_pts = 3'(PTS_GOOD);
            GRADE_PERFECT: base_pts = 3'(PTS_PERFECT);
            default:       base_pts = 3'd0;
        endcase

        new_combo = (combo_q == COMBO_SAT) ? COMBO_SAT : combo_q + 8'd1;

        if (new_combo >= 8'(COMBO_X4)) begin
            mult = 3'd4;
        end else if (new_combo >= 8'(COMBO_X3)) begin
            mult = 3'd3;
        end else if (new_combo >= 8'(COMBO_X2)) begin
            mult = 3'd2;
        end else begin
            mult = 3'd1;
        end

        // Largest product is 5*4=20, so five bits always hold it.
        add_full  = {3'd0, base_pts} * {3'd0, mult};
        add_pts   = add_full[4:0];
        score_sum = {1'b0, score_q} + {11'd0, add_pts};
        score_sat = (score_sum > SCORE_MAX_W) ? SCORE_MAX_W[14:0] : score_sum[14:0];
    end

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        combo_d     = combo_q;
        max_combo_d = max_combo_q;

        case (state_q)
            S_IDLE: begin
                if (game_start) begin
                    state_d     = S_PLAY;
                    score_d     = 15'd0;
                    combo_d     = 8'd0;
                    max_combo_d = 8'd0;
                end
            end
            S_PLAY: begin
                if (game_start) begin
                    // Restart wins over a simultaneous hit, which is dropped.
                    score_d     = 15'd0;
                    combo_d     = 8'd0;
                    max_combo_d = 8'd0;
                end else begin
                    if (hit_valid) begin
                        if (hit_grade == GRADE_MISS) begin
                            combo_d = 8'd0;
                        end else begin
                            score_d     = score_sat;
                            combo_d     = new_combo;
                            max_combo_d = (new_combo > max_combo_q) ? new_combo : max_combo_q;
                        end
                    end
                    if (game_end) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (game_start) begin
                    state_d     = S_PLAY;
                    score_d     = 15'd0;
                    combo_d     = 8'd0;
                    max_combo_d = 8'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        playing_d   = (state_d == S_PLAY);
        game_over_d = (state_d == S_DONE);
    end

    always_ff @(posedge segclk or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            score_q     <= 15'd0;
            combo_q     <= 8'd0;
            max_combo_q <= 8'd0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
        end
    end

    assign score     = score_q;
    assign combo     = combo_q;
    assign max_combo = max_combo_q;
    assign playing   = playing_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_score_accumulator.sv
// Directed-vector bench for score_accumulator with hand-computed expectations.
module tb_score_accumulator;

    logic        segclk;
    logic        clr;
    logic        game_start;
    logic        game_end;
    logic        hit_valid;
    logic [1:0]  hit_grade;
    logic [14:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic        playing;
    logic        game_over;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] MISS = 2'd0, OK = 2'd1, GOOD = 2'd2, PERFECT = 2'd3;

    score_accumulator dut (
        .segclk     (segclk),
        .clr        (clr),
        .game_start (game_start),
        .game_end   (game_end),
        .hit_valid  (hit_valid),
        .hit_grade  (hit_grade),
        .score      (score),
        .combo      (combo),
        .max_combo  (max_combo),
        .playing    (playing),
        .game_over  (game_over)
    );

    initial segclk = 1'b0;
    always #5 segclk = ~segclk;

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // One clock cycle of stimulus; returns #1 after the active edge so outputs are settled.
    task automatic step(input logic st, input logic en, input logic hv, input logic [1:0] gr);
        @(negedge segclk);
        game_start = st;
        game_end   = en;
        hit_valid  = hv;
        hit_grade  = gr;
        @(posedge segclk);
        #1;
        game_start = 1'b0;
        game_end   = 1'b0;
        hit_valid  = 1'b0;
        hit_grade  = 2'd0;
    endtask

    task automatic hits(input int n, input logic [1:0] gr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, gr);
    endtask

    initial begin
        clr        = 1'b1;
        game_start = 1'b0;
        game_end   = 1'b0;
        hit_valid  = 1'b0;
        hit_grade  = 2'd0;
        #2;
        check_val("reset_score", score, 0);
        check_val("reset_playing", playing, 0);
        check_val("reset_game_over", game_over, 0);
        #10;
        clr = 1'b0;

        // 1: build score 37 (7 PERFECT + 1 GOOD), then async clr mid-cycle
        step(1'b1, 1'b0, 1'b0, MISS);
        check_val("t1_playing", playing, 1);
        hits(7, PERFECT);
        hits(1, GOOD);
        check_val("t1_score37", score, 37);
        #2;
        clr = 1'b1;
        #1;
        check_val("t1_async_score", score, 0);
        check_val("t1_async_combo", combo, 0);
        check_val("t1_async_maxc", max_combo, 0);
        check_val("t1_async_playing", playing, 0);
        @(negedge segclk);
        clr = 1'b0;
        hits(1, PERFECT);
        check_val("t1_idle_hit_score", score, 0);
        check_val("t1_idle_playing", playing, 0);

        // 2: ten PERFECT -> 9*5 + 10 = 55
        step(1'b1, 1'b0, 1'b0, MISS);
        hits(9, PERFECT);
        check_val("t2_score9", score, 45);
        hits(1, PERFECT);
        check_val("t2_score", score, 55);
        check_val("t2_combo", combo, 10);
        check_val("t2_maxc", max_combo, 10);

        // 3: restart, 3 GOOD, MISS, 2 OK -> 8, combo 2, max 3
        step(1'b1, 1'b0, 1'b0, MISS);
        check_val("t3_restart_score", score, 0);
        hits(3, GOOD);
        hits(1, MISS);
        check_val("t3_miss_combo", combo, 0);
        check_val("t3_miss_score", score, 6);
        hits(2, OK);
        check_val("t3_score", score, 8);
        check_val("t3_combo", combo, 2);
        check_val("t3_maxc", max_combo, 3);

        // 4: 2000 PERFECT; after 60 hits 45+200+300+11*20=765, then clamp at 9999
        step(1'b1, 1'b0, 1'b0, MISS);
        hits(60, PERFECT);
        check_val("t4_score60", score, 765);
        check_val("t4_combo60", combo, 60);
        hits(1940, PERFECT);
        check_val("t4_score_sat", score, 9999);
        check_val("t4_combo_sat", combo, 255);
        check_val("t4_maxc_sat", max_combo, 255);
        hits(1, MISS);
        check_val("t4_miss_combo", combo, 0);
        check_val("t4_miss_maxc", max_combo, 255);
        hits(1, OK);
        check_val("t4_sat_hold", score, 9999);

        // 5: game_end together with PERFECT at combo 0
        step(1'b1, 1'b0, 1'b0, MISS);
        step(1'b0, 1'b1, 1'b1, PERFECT);
        check_val("t5_score", score, 5);
        check_val("t5_game_over", game_over, 1);
        check_val("t5_playing", playing, 0);
        hits(3, PERFECT);
        check_val("t5_frozen_score", score, 5);
        check_val("t5_frozen_combo", combo, 1);

        // 6: DONE -> PLAY, reach 20, then game_start with a hit drops the hit
        step(1'b1, 1'b0, 1'b0, MISS);
        check_val("t6_playing", playing, 1);
        check_val("t6_game_over", game_over, 0);
        check_val("t6_cleared", score, 0);
        hits(4, PERFECT);
        check_val("t6_score20", score, 20);
        step(1'b1, 1'b0, 1'b1, PERFECT);
        check_val("t6_drop_score", score, 0);
        check_val("t6_drop_combo", combo, 0);
        check_val("t6_drop_maxc", max_combo, 0);
        check_val("t6_still_playing", playing, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_accumulator.md
Name: score_accumulator

Overview:
- Upstream stage of the seven-segment score display in the rhythm-game datapath.
- Consumes one-cycle hit-judgement events from the step/arrow matching logic and keeps a saturating score, a combo count and a max-combo count.
- The score is presented as a 15-bit binary value, at most 9999, that the display stage converts to decimal digits.
- A small game-phase FSM gates scoring; the result freezes at game end.

Parameters:
- PTS_OK, 1, base points for an OK hit
- PTS_GOOD, 2, base points for a GOOD hit
- PTS_PERFECT, 5, base points for a PERFECT hit
- COMBO_X2, 10, combo count at or above which the multiplier is 2
- COMBO_X3, 30, combo count at or above which the multiplier is 3
- COMBO_X4, 50, combo count at or above which the multiplier is 4
- SCORE_MAX, 9999, saturation ceiling for the score

Ports:
- segclk  in  1  system clock; the display stage also runs on it
- clr  in  1  reset, asynchronous, active-high
- game_start  in  1  one-cycle pulse; starts or restarts a game
- game_end  in  1  one-cycle pulse; ends the game and freezes results
- hit_valid  in  1  one-cycle strobe; a judgement is present this cycle
- hit_grade  in  2  judgement: 0=MISS, 1=OK, 2=GOOD, 3=PERFECT
- score  out  15  registered score, 0..SCORE_MAX; bit i drives the display's score input i
- combo  out  8  current consecutive non-miss count
- max_combo  out  8  highest combo reached this game
- playing  out  1  1 while the FSM is in PLAY
- game_over  out  1  1 while the FSM is in DONE

Behaviour:
- Reset, asynchronous while clr=1:
  - state=IDLE
  - score=0, combo=0, max_combo=0, playing=0, game_over=0
- FSM states: IDLE, PLAY, DONE. All outputs are registered.
- IDLE:
  - hit_valid and game_end are ignored.
  - game_start -> PLAY, and score, combo and max_combo are cleared in the same edge.
- PLAY:
  - game_start restarts the game: counters clear and the state stays PLAY.
  - game_start takes priority over a hit in the same cycle; that hit is dropped.
  - game_end -> DONE. A hit_valid in the same cycle is still scored before the freeze.
- DONE:
  - Hits and game_end are ignored; outputs hold.
  - game_start -> PLAY with counters cleared.
- Hit processing, PLAY only:
  - Results are visible one segclk after the hit_valid cycle.
  - MISS: combo<=0; score unchanged; max_combo unchanged.
  - Non-miss:
    - new_combo = combo+1, saturating at 255.
    - mult = 4 if new_combo>=COMBO_X4, else 3 if >=COMBO_X3, else 2 if >=COMBO_X2, else 1.
    - add = base(grade)*mult, at most 20 and 5 bits wide.
    - score <= min(score+add, SCORE_MAX). Compute in 16 bits, then compare and clamp.
    - combo <= new_combo.
    - max_combo <= max(max_combo, new_combo).
- Saturation:
  - At SCORE_MAX, further hits still update combo and max_combo; the score stays at 9999.
  - combo holds at 255 and does not wrap; the multiplier stays at 4.
- Back-to-back hit_valid on consecutive cycles is legal; each is processed, with no stall and no lost event.
- hit_grade is sampled only when hit_valid=1.
- playing = (state==PLAY) and game_over = (state==DONE); both are registered alongside the state.
- clr mid-game: an immediate asynchronous return to IDLE with all outputs 0. The first edge after clr falls gives no spurious update.

Test Plan:
1. clr pulse mid-PLAY with score=37 -> all outputs 0 asynchronously, state IDLE; a hit_valid while in IDLE leaves score=0.
2. game_start, then 10 consecutive PERFECT hits -> combos 1..9 score 5 each (45), the 10th scores x2 (10); final score=55, combo=10, max_combo=10.
3. game_start, then 3 GOOD, 1 MISS, 2 OK -> score=8, combo=2, max_combo=3.
4. Preload via 2000 PERFECT hits (x4 once combo>=50) -> score clamps at 9999 exactly, never wraps; combo=255, max_combo=255.
5. game_end coincident with a PERFECT hit at combo 0 -> score+=5, then game_over=1 and playing=0; later hits do not change score.
6. game_start coincident with hit_valid in PLAY (score=20) -> next cycle score=0 and combo=0 with the hit dropped; game_start from DONE returns playing=1.
